la_capture_ctrl: RTL and testbench
==================================

# la_capture_ctrl

Trigger-and-capture controller for user-project logic-analyzer probes. It samples a DW-bit probe word into a circular buffer. It evaluates a masked-match trigger and holds a programmable number of pre-trigger samples. After the trigger it fills the buffer and freezes, then serves trigger-relative readout. It also drives a 16-bit status code that firmware and benches observe on mprj_io[31:16].

## Interface
- DW, 32, probe sample width
- AW, 6, buffer address width; DEPTH = 2**AW samples
- clock  in  1  single clock, all logic rising-edge
- resetb  in  1  asynchronous, active-low reset
- cfg_arm  in  1  single-cycle pulse: start capture
- cfg_abort  in  1  single-cycle pulse: return to IDLE
- cfg_pre  in  AW  pre-trigger sample count, 0..DEPTH-1
- trig_mask  in  DW  bits compared by trigger
- trig_value  in  DW  required value of masked bits
- sample_in  in  DW  probe word
- sample_valid  in  1  sample_in is a new sample this cycle
- rd_idx  in  AW  logical read index, 0 = oldest captured sample
- rd_data  out  DW  buffer word for rd_idx, registered
- trig_pos  out  AW  physical address of the trigger sample
- done  out  1  capture complete, buffer frozen
- state_o  out  3  current FSM state
- status_code  out  16  16'hAB60 | state_o

## Operation
- States: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
- Trigger hit: sample_valid && ((sample_in ^ trig_value) & trig_mask) == 0. With mask 0, the first valid sample evaluated hits.
- IDLE: cfg_arm -> wr_ptr=0, cnt=0; go to PRE if cfg_pre!=0, else WAIT.
- PRE: each valid sample is written at wr_ptr, then wr_ptr++ and cnt++. The trigger is not evaluated. When the write makes cnt==cfg_pre, go to WAIT.
- WAIT: each valid sample is written at wr_ptr, then wr_ptr++. Writes wrap modulo DEPTH and overwrite the oldest sample. On a hit, the hit sample is written, trig_pos=wr_ptr, and post=DEPTH-1-cfg_pre. The FSM goes to DONE if post==0, else POST.
- POST: each valid sample is written, then wr_ptr++ and post--. The write that makes post reach 0 moves the FSM to DONE.
- DONE: no writes. done=1. cfg_arm re-arms exactly as from IDLE.
- cfg_arm outside IDLE/DONE is ignored.
- cfg_abort in any state -> IDLE next cycle, done=0. When cfg_arm and cfg_abort arrive together, abort wins.
- Readout: phys = (trig_pos - cfg_pre + rd_idx) mod DEPTH, computed with AW-bit wrap arithmetic. Contents are defined only in DONE. cfg_pre must be held stable from arm through readout.
- Cycles with sample_valid=0 change no pointer or counter.

## Timing
- Reset values: state IDLE, wr_ptr=0, cnt=0, post=0, trig_pos=0, done=0, state_o=0, status_code=16'hAB60, rd_data=0. RAM contents are undefined.
- A buffer write happens on the same edge as the accepted sample.
- State, done and status_code update on the edge that accepts the causing sample or pulse.
- rd_data is valid 1 cycle after rd_idx is presented.
- No DEPTH-cycle minimum: WAIT may trigger before the buffer wraps. Buffer slots older than the filled pre-trigger samples hold stale data.

## Structure
- Package la_capture_pkg holds the state enum/localparams (IDLE..DONE), STATUS_BASE=16'hAB60, and the trigger-match function.
- Sub-module la_capture_buf is a DEPTH×DW simple dual-port RAM with one write port and one registered read port. It is separated so a macro can replace it.
- The controller FSM, pointers and address arithmetic live in la_capture_ctrl.

## Test plan
- Reset: hold resetb=0 mid-POST, then release. Required: done=0, status_code=16'hAB60, state_o=0. A sample then causes no change until cfg_arm.
- cfg_pre=0, mask=0, arm, ramp sample_in=0x100+n. Required: trigger on 0x100, done after 0x13F. rd_idx 0 -> 0x100, rd_idx 63 -> 0x13F, status_code 16'hAB64.
- cfg_pre=16, mask=0xFF, value=0x5A, ramp 0,1,2…. Required: trig_pos=0x1A, rd_idx 0 -> 0x4A, rd_idx 16 -> 0x5A, rd_idx 63 -> 0x89, done the cycle after 0x89.
- cfg_pre=63, mask=0xFF, value=0xC8, ramp from 0. Required: post=0, so DONE is entered directly on 0xC8. rd_idx 63 -> 0xC8, rd_idx 0 -> 0x89, with wrap across address 0 verified.
- Gapped sample_valid (50% random), cfg_pre=4, value 0x05 coincident with the 4th PRE sample. Required: the PRE-phase match is ignored, pointers freeze on gaps, and the trigger fires at the next 0x05 in WAIT.
- cfg_abort during POST, with cfg_arm simultaneously. Required: IDLE next cycle, done=0, status_code 16'hAB60. A later cfg_arm restarts cleanly.

Source files
------------

// File: rtl/la_capture_pkg.sv
// ============================================================================
// Module   : la_capture_pkg
// Purpose  : Shared state encoding, status base and trigger match helper for
//            the logic-analyzer capture controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package la_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } la_state_e;

  localparam logic [15:0] STATUS_BASE = 16'hAB60;

  // Widest probe supported by the match helper; narrower probes are zero-extended.
  localparam int unsigned MATCH_W = 64;

  function automatic logic trig_hit(
    input logic               valid,
    input logic [MATCH_W-1:0] sample,
    input logic [MATCH_W-1:0] value,
    input logic [MATCH_W-1:0] mask
  );
    return valid && (((sample ^ value) & mask) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/la_capture_buf.sv
// ============================================================================
// Module   : la_capture_buf
// Purpose  : DEPTH x DW simple dual-port sample RAM, one write port and one
//            registered read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module la_capture_buf #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Storage has no reset so a vendor macro can drop in unchanged.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/la_capture_ctrl.sv
// ============================================================================
// Module   : la_capture_ctrl
// Purpose  : Trigger-and-capture controller: pre-trigger ring buffering,
//            masked trigger match, post-trigger fill and relative readout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module la_capture_ctrl
  import la_capture_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clock,
  input  logic          resetb,
  input  logic          cfg_arm,
  input  logic          cfg_abort,
  input  logic [AW-1:0] cfg_pre,
  input  logic [DW-1:0] trig_mask,
  input  logic [DW-1:0] trig_value,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  input  logic [AW-1:0] rd_idx,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] trig_pos,
  output logic          done,
  output logic [2:0]    state_o,
  output logic [15:0]   status_code
);

  la_state_e     r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_post;
  logic [AW-1:0] r_trig_pos;
  logic          r_done;

  logic          w_hit;
  logic          w_we;
  logic [AW-1:0] w_cnt_nxt;
  logic [AW-1:0] w_post_init;
  logic [AW-1:0] w_raddr;

  assign w_hit = trig_hit(sample_valid, MATCH_W'(sample_in),
                          MATCH_W'(trig_value), MATCH_W'(trig_mask));

  assign w_we = sample_valid && !cfg_abort &&
                ((r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST));

  assign w_cnt_nxt = r_cnt + 1'b1;

  // DEPTH-1-cfg_pre in AW-bit arithmetic is simply the bitwise complement.
  assign w_post_init = ~cfg_pre;

  assign w_raddr = r_trig_pos - cfg_pre + rd_idx;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
      r_post     <= '0;
      r_trig_pos <= '0;
      r_done     <= 1'b0;
    end else if (cfg_abort) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (cfg_arm) begin
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_state  <= (cfg_pre != '0) ? ST_PRE : ST_WAIT;
          end
        end
        ST_PRE: begin
          if (sample_valid) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_cnt    <= w_cnt_nxt;
            if (w_cnt_nxt == cfg_pre) begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (sample_valid) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_hit) begin
              r_trig_pos <= r_wr_ptr;
              r_post     <= w_post_init;
              if (w_post_init == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (sample_valid) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_post   <= r_post - 1'b1;
            if (r_post == {{(AW-1){1'b0}}, 1'b1}) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  la_capture_buf #(
    .DW (DW),
    .AW (AW)
  ) u_buf (
    .clk     (clock),
    .rst_n   (resetb),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (sample_in),
    .i_raddr (w_raddr),
    .o_rdata (rd_data)
  );

  assign trig_pos    = r_trig_pos;
  assign done        = r_done;
  assign state_o     = r_state;
  assign status_code = STATUS_BASE | {13'd0, r_state};

endmodule

`default_nettype wire

// File: tb/tb_la_capture_ctrl.sv
// ============================================================================
// Module   : tb_la_capture_ctrl
// Purpose  : Directed self-checking bench for la_capture_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_la_capture_ctrl;

  logic        clock = 1'b0;
  logic        resetb;
  logic        cfg_arm;
  logic        cfg_abort;
  logic [5:0]  cfg_pre;
  logic [31:0] trig_mask;
  logic [31:0] trig_value;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic [5:0]  rd_idx;
  logic [31:0] rd_data;
  logic [5:0]  trig_pos;
  logic        done;
  logic [2:0]  state_o;
  logic [15:0] status_code;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  la_capture_ctrl #(.DW(32), .AW(6)) dut (
    .clock        (clock),
    .resetb       (resetb),
    .cfg_arm      (cfg_arm),
    .cfg_abort    (cfg_abort),
    .cfg_pre      (cfg_pre),
    .trig_mask    (trig_mask),
    .trig_value   (trig_value),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .rd_idx       (rd_idx),
    .rd_data      (rd_data),
    .trig_pos     (trig_pos),
    .done         (done),
    .state_o      (state_o),
    .status_code  (status_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    sample_valid = 1'b1;
    sample_in    = d;
    tick();
    sample_valid = 1'b0;
    sample_in    = 32'h5;
  endtask

  task automatic gap();
    sample_valid = 1'b0;
    sample_in    = 32'h5;
    tick();
  endtask

  task automatic push_g(input logic [31:0] d);
    if ($urandom_range(0, 1) == 1) gap();
    push(d);
  endtask

  task automatic arm(input logic [5:0] pre, input logic [31:0] mask, input logic [31:0] val);
    cfg_pre    = pre;
    trig_mask  = mask;
    trig_value = val;
    cfg_arm    = 1'b1;
    tick();
    cfg_arm    = 1'b0;
  endtask

  task automatic rd(input logic [5:0] idx, input logic [31:0] exp, input string tag);
    rd_idx = idx;
    tick();
    chk(tag, rd_data, exp);
  endtask

  initial begin
    resetb       = 1'b0;
    cfg_arm      = 1'b0;
    cfg_abort    = 1'b0;
    cfg_pre      = '0;
    trig_mask    = '0;
    trig_value   = '0;
    sample_in    = '0;
    sample_valid = 1'b0;
    rd_idx       = '0;
    repeat (3) tick();
    resetb = 1'b1;
    tick();

    // Power-on reset state
    chk("por_state", 32'(state_o), 32'd0);
    chk("por_status", 32'(status_code), 32'h0000AB60);
    chk("por_done", 32'(done), 32'd0);
    chk("por_trig_pos", 32'(trig_pos), 32'd0);
    chk("por_rd_data", rd_data, 32'd0);

    // Reset asserted mid-POST
    arm(6'd0, 32'h0, 32'h0);
    chk("arm_pre0_wait", 32'(state_o), 32'd2);
    push(32'h300);
    push(32'h301);
    chk("mid_post_state", 32'(state_o), 32'd3);
    #2 resetb = 1'b0;
    #1;
    chk("rst_async_state", 32'(state_o), 32'd0);
    tick();
    resetb = 1'b1;
    tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_status", 32'(status_code), 32'h0000AB60);
    chk("rst_done", 32'(done), 32'd0);
    push(32'h0);
    chk("rst_idle_sample", 32'(state_o), 32'd0);

    // pre=0, mask=0: first sample triggers
    arm(6'd0, 32'h0, 32'h0);
    for (int n = 0; n < 63; n++) push(32'h100 + 32'(n));
    chk("t1_not_done", 32'(done), 32'd0);
    push(32'h13F);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_trig_pos", 32'(trig_pos), 32'd0);
    chk("t1_status", 32'(status_code), 32'h0000AB64);
    rd(6'd0, 32'h100, "t1_rd0");
    rd(6'd63, 32'h13F, "t1_rd63");

    // pre=16, value 0x5A (re-armed from DONE)
    arm(6'd16, 32'hFF, 32'h5A);
    chk("t2_pre_state", 32'(state_o), 32'd1);
    for (int n = 0; n < 16'h89; n++) push(32'(n));
    chk("t2_not_done", 32'(done), 32'd0);
    push(32'h89);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_trig_pos", 32'(trig_pos), 32'h1A);
    rd(6'd0, 32'h4A, "t2_rd0");
    rd(6'd16, 32'h5A, "t2_rd16");
    rd(6'd63, 32'h89, "t2_rd63");

    // pre=63: post count zero, DONE directly on the hit
    arm(6'd63, 32'hFF, 32'hC8);
    for (int n = 0; n < 16'hC8; n++) push(32'(n));
    chk("t3_wait_state", 32'(state_o), 32'd2);
    push(32'hC8);
    chk("t3_done_state", 32'(state_o), 32'd4);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_trig_pos", 32'(trig_pos), 32'd8);
    rd(6'd63, 32'hC8, "t3_rd63");
    rd(6'd0, 32'h89, "t3_rd0");
    rd(6'd55, 32'hC0, "t3_rd55_addr0");
    rd(6'd54, 32'hBF, "t3_rd54_addr63");
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("t3_abort_done", 32'(done), 32'd0);
    chk("t3_abort_state", 32'(state_o), 32'd0);

    // Gapped samples, PRE-phase match ignored, arm in WAIT ignored
    arm(6'd4, 32'hFF, 32'h05);
    push_g(32'h02);
    push_g(32'h03);
    push_g(32'h04);
    push_g(32'h05);
    chk("t4_wait_after_pre", 32'(state_o), 32'd2);
    gap();
    chk("t4_gap_state", 32'(state_o), 32'd2);
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    chk("t4_arm_ignored", 32'(state_o), 32'd2);
    push_g(32'h06);
    push_g(32'h07);
    push_g(32'h05);
    chk("t4_post_state", 32'(state_o), 32'd3);
    chk("t4_trig_pos", 32'(trig_pos), 32'd6);
    for (int k = 0; k < 58; k++) push_g(32'h100 + 32'(k));
    chk("t4_not_done", 32'(done), 32'd0);
    push_g(32'h13A);
    chk("t4_done", 32'(done), 32'd1);
    rd(6'd0, 32'h04, "t4_rd0");
    rd(6'd4, 32'h05, "t4_rd4");
    rd(6'd5, 32'h100, "t4_rd5");
    rd(6'd63, 32'h13A, "t4_rd63");

    // Abort with simultaneous arm during POST
    arm(6'd0, 32'h0, 32'h0);
    push(32'h200);
    push(32'h201);
    chk("t5_post_state", 32'(state_o), 32'd3);
    cfg_arm   = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_arm   = 1'b0;
    cfg_abort = 1'b0;
    chk("t5_abort_state", 32'(state_o), 32'd0);
    chk("t5_abort_done", 32'(done), 32'd0);
    chk("t5_abort_status", 32'(status_code), 32'h0000AB60);
    arm(6'd16, 32'hFF, 32'h5A);
    chk("t5_rearm_state", 32'(state_o), 32'd1);
    for (int n = 0; n < 16; n++) push(32'(n));
    chk("t5_rearm_wait", 32'(state_o), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
